stim_seq_player: RTL and testbench
==================================

Name: stim_seq_player

Overview:
- Parametrised, synthesisable vector player/checker for FSM-style DUTs driven by an {rst, in} stream.
- Holds DEPTH vectors, each {expected output, DUT reset bit, DUT input}, loaded through a write port.
- On start, drives one vector per clock into the DUT, compares the DUT output against the expected value after a fixed latency, and reports mismatch count and first failing index.
- Sits beside the DUT in on-chip self-test and bench harnesses; replaces file-driven stimulus loops.

Parameters:
- IN_LEN, 8, DUT input width.
- OUT_LEN, 19, DUT output width.
- DEPTH, 110, vector storage depth (≥2).
- AW, 7, address/index width; must satisfy 2^AW ≥ DEPTH.
- CMP_LAT, 1, cycles from vector driven on dut_in to matching dut_out (1..4).
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- ld_en  in  1  vector write strobe.
- ld_addr  in  AW  vector write address.
- ld_data  in  OUT_LEN+1+IN_LEN  {exp, vrst, vin}, MSB first.
- num_vec  in  AW+1  vectors to play; sampled on start.
- start  in  1  one-cycle start pulse.
- abort  in  1  stop playback.
- dut_rst  out  1  reset bit to DUT, active-high, registered.
- dut_in  out  IN_LEN  DUT input, registered.
- dut_out  in  OUT_LEN  DUT output to check.
- busy  out  1  high in PLAY/DRAIN.
- done  out  1  high in DONE.
- err_cnt  out  ERR_W  mismatch count, saturating.
- first_err_vld  out  1  at least one mismatch seen.
- first_err_idx  out  AW  index of first mismatching vector.
- cur_idx  out  AW  index of vector currently on dut_in.

Behaviour:
- Reset (rst=0, async): state IDLE; dut_rst=1, dut_in=0, busy=0, done=0, err_cnt=0, first_err_vld=0, first_err_idx=0, cur_idx=0; compare pipeline cleared. Memory contents are not reset.
- Load: ld_en writes ld_data to mem[ld_addr] at the clock edge, in IDLE and DONE only. Ignored in PLAY/DRAIN. Addresses ≥ DEPTH are ignored.
- States IDLE, PLAY, DRAIN, DONE.
- IDLE → PLAY on start with 0 < num_vec ≤ DEPTH. num_vec is latched and err_cnt, first_err_* are cleared. With num_vec = 0 or > DEPTH: go straight to DONE with err_cnt unchanged.
- PLAY: edge n after entry (n = 0..N-1) loads dut_rst/dut_in from mem[n] and sets cur_idx=n. After index N-1: → DRAIN.
- DRAIN: lasts CMP_LAT cycles; dut_rst=1, dut_in held; then → DONE.
- DONE: done=1 until start (→ PLAY, or DONE as above) or abort (→ IDLE).
- Compare: for the vector driven at edge e, dut_out is sampled at edge e+CMP_LAT via a CMP_LAT-deep pipeline of {valid, exp, vrst, idx}.
  - Compare is skipped when vrst=1.
  - Mismatch: err_cnt += 1, saturating at 2^ERR_W-1.
  - If first_err_vld=0: set first_err_vld and latch first_err_idx=idx.
- abort in PLAY/DRAIN: next edge → IDLE; dut_rst=1; pipeline flushed with no further compares; counters hold their values.
- start while busy: ignored. start and abort in the same cycle: abort wins.
- Async reset mid-play: immediate return to reset values.

Optional Feature:
- Macro STIM_SEQ_LOOP_EN.
- Defined: adds input `loop`, sampled on start. If loop=1, PLAY wraps from index N-1 back to 0 with no gap cycle and never enters DRAIN. Playback runs until abort. err_cnt keeps accumulating across passes.
- Undefined: no `loop` port; single pass exactly as above.

Test Plan:
- Reset then idle: outputs at reset values; dut_rst=1 held; start with num_vec=0 → done=1 next cycle, err_cnt=0.
- Load 110 vectors with exp equal to a CMP_LAT=1 registered-echo DUT (out = prior in, zero-extended); vectors 0-1 have vrst=1. Start num_vec=110 → busy for 111 cycles, done=1, err_cnt=0, first_err_vld=0.
- Corrupt exp of vectors 37 and 80 → err_cnt=2, first_err_idx=37.
- Corrupt exp only on vector 5, which has vrst=1 → err_cnt=0 (skipped).
- Abort at cycle 20 of PLAY → IDLE next edge, dut_rst=1, err_cnt holds; ld_en during PLAY leaves memory unchanged.
- Tie dut_out to a constant mismatch, ERR_W=4, num_vec=30 → err_cnt saturates at 15. With STIM_SEQ_LOOP_EN, loop=1, num_vec=3 → cur_idx sequence 0,1,2,0,1,2 until abort.

Source files
------------

// File: rtl/stim_seq_player.sv
// ============================================================================
// Module   : stim_seq_player
// Purpose  : Vector player/checker: drives {rst,in} vectors into a DUT and
//            counts output mismatches after CMP_LAT cycles.
// Option   : STIM_SEQ_LOOP_EN adds a 'loop' input for continuous playback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stim_seq_player #(
  parameter int IN_LEN  = 8,
  parameter int OUT_LEN = 19,
  parameter int DEPTH   = 110,
  parameter int AW      = 7,
  parameter int CMP_LAT = 1,
  parameter int ERR_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_en,
  input  logic [AW-1:0]             ld_addr,
  input  logic [OUT_LEN+IN_LEN:0]   ld_data,
  input  logic [AW:0]               num_vec,
  input  logic                      start,
  input  logic                      abort,
`ifdef STIM_SEQ_LOOP_EN
  input  logic                      loop,
`endif
  output logic                      dut_rst,
  output logic [IN_LEN-1:0]         dut_in,
  input  logic [OUT_LEN-1:0]        dut_out,
  output logic                      busy,
  output logic                      done,
  output logic [ERR_W-1:0]          err_cnt,
  output logic                      first_err_vld,
  output logic [AW-1:0]             first_err_idx,
  output logic [AW-1:0]             cur_idx
);

  localparam int            c_VW        = OUT_LEN + 1 + IN_LEN;
  localparam logic [AW:0]   c_DEPTH     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_NUM_ONE   = 1;
  localparam logic [AW-1:0] c_PTR_ONE   = 1;
  localparam logic [ERR_W-1:0] c_ERR_ONE = 1;
  localparam logic [2:0]    c_DRAIN_END = 3'(CMP_LAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [c_VW-1:0]    r_mem [0:DEPTH-1];
  logic [1:0]         r_state;
  logic [AW:0]        r_num;
  logic [AW-1:0]      r_rd_ptr;
  logic [2:0]         r_drain_cnt;
  logic               r_dut_rst;
  logic [IN_LEN-1:0]  r_dut_in;
  logic [AW-1:0]      r_cur_idx;
  logic [ERR_W-1:0]   r_err_cnt;
  logic               r_first_vld;
  logic [AW-1:0]      r_first_idx;

  // Compare pipeline: stage k holds the vector driven k+1 edges ago.
  logic               r_pv    [CMP_LAT];
  logic [OUT_LEN-1:0] r_pexp  [CMP_LAT];
  logic               r_pvrst [CMP_LAT];
  logic [AW-1:0]      r_pidx  [CMP_LAT];

  logic [c_VW-1:0]    w_vec;
  logic [OUT_LEN-1:0] w_vec_exp;
  logic               w_vec_rst;
  logic [IN_LEN-1:0]  w_vec_in;
  logic               w_idle_or_done;
  logic               w_ld_ok;
  logic               w_start_ok;
  logic               w_nv_ok;
  logic               w_last;
  logic               w_push;
  logic               w_cmp_fail;
  logic               w_loop;

`ifdef STIM_SEQ_LOOP_EN
  logic r_loop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_loop <= 1'b0;
    end else if (w_start_ok && w_nv_ok) begin
      r_loop <= loop;
    end
  end

  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_vec          = r_mem[r_rd_ptr];
  assign w_vec_exp      = w_vec[c_VW-1 -: OUT_LEN];
  assign w_vec_rst      = w_vec[IN_LEN];
  assign w_vec_in       = w_vec[IN_LEN-1:0];
  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_ld_ok        = ld_en && w_idle_or_done && ({1'b0, ld_addr} < c_DEPTH);
  assign w_start_ok     = start && !abort && w_idle_or_done;
  assign w_nv_ok        = (num_vec != '0) && (num_vec <= c_DEPTH);
  assign w_last         = ({1'b0, r_rd_ptr} == (r_num - c_NUM_ONE));
  assign w_push         = (r_state == S_PLAY) && !abort;
  assign w_cmp_fail     = r_pv[CMP_LAT-1] && !r_pvrst[CMP_LAT-1] && !abort &&
                          (dut_out != r_pexp[CMP_LAT-1]);

  // Vector storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_ld_ok) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_rd_ptr    <= '0;
      r_drain_cnt <= '0;
      r_dut_rst   <= 1'b1;
      r_dut_in    <= '0;
      r_cur_idx   <= '0;
      r_err_cnt   <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
      for (int k = 0; k < CMP_LAT; k++) begin
        r_pv[k]    <= 1'b0;
        r_pexp[k]  <= '0;
        r_pvrst[k] <= 1'b0;
        r_pidx[k]  <= '0;
      end
    end else begin
      r_pv[0]    <= w_push;
      r_pexp[0]  <= w_vec_exp;
      r_pvrst[0] <= w_vec_rst;
      r_pidx[0]  <= r_rd_ptr;
      for (int k = 1; k < CMP_LAT; k++) begin
        r_pv[k]    <= r_pv[k-1];
        r_pexp[k]  <= r_pexp[k-1];
        r_pvrst[k] <= r_pvrst[k-1];
        r_pidx[k]  <= r_pidx[k-1];
      end

      if (w_cmp_fail) begin
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + c_ERR_ONE;
        end
        if (!r_first_vld) begin
          r_first_vld <= 1'b1;
          r_first_idx <= r_pidx[CMP_LAT-1];
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            if (w_nv_ok) begin
              r_state     <= S_PLAY;
              r_num       <= num_vec;
              r_rd_ptr    <= '0;
              r_err_cnt   <= '0;
              r_first_vld <= 1'b0;
              r_first_idx <= '0;
            end else begin
              r_state <= S_DONE;
            end
          end else if (abort) begin
            r_state <= S_IDLE;
          end
        end
        S_PLAY: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_dut_rst <= 1'b1;
            for (int k = 0; k < CMP_LAT; k++) r_pv[k] <= 1'b0;
          end else begin
            r_dut_rst <= w_vec_rst;
            r_dut_in  <= w_vec_in;
            r_cur_idx <= r_rd_ptr;
            if (w_last) begin
              r_rd_ptr <= '0;
              if (!w_loop) begin
                r_state     <= S_DRAIN;
                r_drain_cnt <= '0;
              end
            end else begin
              r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
          end
        end
        S_DRAIN: begin
          r_dut_rst <= 1'b1;
          if (abort) begin
            r_state <= S_IDLE;
            for (int k = 0; k < CMP_LAT; k++) r_pv[k] <= 1'b0;
          end else if (r_drain_cnt == c_DRAIN_END) begin
            r_state <= S_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_rst       = r_dut_rst;
  assign dut_in        = r_dut_in;
  assign busy          = (r_state == S_PLAY) || (r_state == S_DRAIN);
  assign done          = (r_state == S_DONE);
  assign err_cnt       = r_err_cnt;
  assign first_err_vld = r_first_vld;
  assign first_err_idx = r_first_idx;
  assign cur_idx       = r_cur_idx;

endmodule

`default_nettype wire

// File: tb/tb_stim_seq_player.sv
// ============================================================================
// Module   : tb_stim_seq_player
// Purpose  : Scoreboard bench for stim_seq_player with a registered-echo DUT
//            and a second ERR_W=4 instance driven against a constant output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stim_seq_player;

  localparam logic [27:0] c_CORR = 28'h8000000;

  typedef struct {
    int err;
    int vld;
    int idx;
    int bc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_en = 1'b0;
  logic [6:0]  ld_addr = '0;
  logic [27:0] ld_data = '0;
  logic [7:0]  num_vec = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
`ifdef STIM_SEQ_LOOP_EN
  logic        loop = 1'b0;
`endif

  logic        dut_rst, busy, done, first_err_vld;
  logic [7:0]  dut_in;
  logic [18:0] dut_out;
  logic [15:0] err_cnt;
  logic [6:0]  first_err_idx, cur_idx;

  logic        s_dut_rst, s_busy, s_done, s_first_err_vld;
  logic [7:0]  s_dut_in;
  logic [3:0]  s_err_cnt;
  logic [6:0]  s_first_err_idx, s_cur_idx;
  logic [18:0] s_dut_out;

  logic [18:0] echo = '0;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Registered-echo DUT: output is the previous input, zero-extended.
  always @(posedge clk) echo <= {11'd0, dut_in};
  assign dut_out   = echo;
  assign s_dut_out = 19'h7FFFF;

  stim_seq_player u_dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .num_vec(num_vec), .start(start), .abort(abort),
`ifdef STIM_SEQ_LOOP_EN
    .loop(loop),
`endif
    .dut_rst(dut_rst), .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .err_cnt(err_cnt), .first_err_vld(first_err_vld), .first_err_idx(first_err_idx),
    .cur_idx(cur_idx)
  );

  stim_seq_player #(.ERR_W(4)) u_sat (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .num_vec(num_vec), .start(start), .abort(abort),
`ifdef STIM_SEQ_LOOP_EN
    .loop(loop),
`endif
    .dut_rst(s_dut_rst), .dut_in(s_dut_in), .dut_out(s_dut_out), .busy(s_busy), .done(s_done),
    .err_cnt(s_err_cnt), .first_err_vld(s_first_err_vld), .first_err_idx(s_first_err_idx),
    .cur_idx(s_cur_idx)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic logic [7:0] vin_of(input int n);
    return 8'((n * 37 + 11) % 256);
  endfunction

  function automatic logic [27:0] vec_of(input int n);
    logic [18:0] e;
    logic        r;
    e = (n == 0) ? 19'd0 : {11'd0, vin_of(n - 1)};
    r = (n < 2);
    return {e, r, vin_of(n)};
  endfunction

  task automatic push_exp(input int e, input int v, input int i, input int b);
    exp_t x;
    x.err = e; x.vld = v; x.idx = i; x.bc = b;
    sb_q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int a, input logic [27:0] d);
    ld_addr = 7'(a);
    ld_data = d;
    ld_en   = 1'b1;
    tick(1);
    ld_en   = 1'b0;
  endtask

  task automatic pulse_start(input int n);
    num_vec = 8'(n);
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", max);
    end
  endtask

  // Monitor: on each rising done, pop the expected result and compare.
  bit prev_done = 1'b0;
  bit prev_busy = 1'b0;
  int busy_cyc  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_done = 1'b0;
      prev_busy = 1'b0;
      busy_cyc  = 0;
    end else begin
      if (busy && !prev_busy) busy_cyc = 0;
      if (busy) busy_cyc++;
      if (done && !prev_done) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL done_unexpected: got done=1 expected no completion");
        end else begin
          e = sb_q.pop_front();
          chk("sb_err_cnt", 64'(err_cnt), 64'(e.err));
          chk("sb_first_err_vld", 64'(first_err_vld), 64'(e.vld));
          chk("sb_first_err_idx", 64'(first_err_idx), 64'(e.idx));
          chk("sb_busy_cycles", 64'(busy_cyc), 64'(e.bc));
        end
      end
      prev_done = done;
      prev_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [27:0] d;

    tick(3);
    @(negedge clk);
    chk("rst_dut_rst", 64'(dut_rst), 64'd1);
    chk("rst_dut_in", 64'(dut_in), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_first_vld", 64'(first_err_vld), 64'd0);
    chk("rst_first_idx", 64'(first_err_idx), 64'd0);
    chk("rst_cur_idx", 64'(cur_idx), 64'd0);
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    chk("idle_dut_rst", 64'(dut_rst), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    push_exp(0, 0, 0, 0);
    pulse_start(0);
    @(negedge clk);
    chk("nv0_done", 64'(done), 64'd1);

    for (int n = 0; n < 110; n++) load(n, vec_of(n));

    push_exp(0, 0, 0, 111);
    pulse_start(110);
    wait_done(300);

    load(37, vec_of(37) ^ c_CORR);
    load(80, vec_of(80) ^ c_CORR);
    push_exp(2, 1, 37, 111);
    pulse_start(110);
    wait_done(300);
    load(37, vec_of(37));
    load(80, vec_of(80));

    d = vec_of(5);
    d[8] = 1'b1;
    load(5, d ^ c_CORR);
    push_exp(0, 0, 0, 111);
    pulse_start(110);
    wait_done(300);
    load(5, vec_of(5));

    load(10, vec_of(10) ^ c_CORR);
    pulse_start(110);
    tick(5);
    ld_addr = 7'd50;
    ld_data = vec_of(50) ^ c_CORR;
    ld_en   = 1'b1;
    tick(3);
    ld_en   = 1'b0;
    tick(12);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_dut_rst", 64'(dut_rst), 64'd1);
    chk("abort_err_cnt", 64'(err_cnt), 64'd1);
    chk("abort_first_idx", 64'(first_err_idx), 64'd10);
    tick(3);
    @(negedge clk);
    chk("abort_err_hold", 64'(err_cnt), 64'd1);
    load(10, vec_of(10));
    push_exp(0, 0, 0, 111);
    pulse_start(110);
    wait_done(300);

    push_exp(0, 0, 0, 31);
    pulse_start(30);
    wait_done(100);
    chk("sat_done", 64'(s_done), 64'd1);
    chk("sat_err_cnt", 64'(s_err_cnt), 64'd15);
    chk("sat_first_vld", 64'(s_first_err_vld), 64'd1);
    chk("sat_first_idx", 64'(s_first_err_idx), 64'd2);

    pulse_start(111);
    @(negedge clk);
    chk("nvbig_done", 64'(done), 64'd1);
    chk("nvbig_busy", 64'(busy), 64'd0);
    chk("nvbig_sat_err", 64'(s_err_cnt), 64'd15);

`ifdef STIM_SEQ_LOOP_EN
    loop = 1'b1;
    pulse_start(3);
    loop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("loop_cur_idx", 64'(cur_idx), 64'(i % 3));
    end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge clk);
    chk("loop_abort_busy", 64'(busy), 64'd0);
`endif

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
